// File: rtl/ni_recv_dma_pkg.sv
// Shared types and constants for the NI receive DMA: FSM states, flit/word widths, byte-lane strobes.
package ni_pkg;

   localparam int unsigned FLIT_WIDTH     = 16;
   localparam int unsigned ADDR_WIDTH     = 32;
   localparam int unsigned LEN_WIDTH      = 16;
   localparam int unsigned FLITS_PER_WORD = 2;
   localparam int unsigned WORD_WIDTH     = FLIT_WIDTH * FLITS_PER_WORD;
   localparam int unsigned WB_WIDTH       = 4;

   localparam logic [WB_WIDTH-1:0] WB_NONE     = 4'b0000;
   localparam logic [WB_WIDTH-1:0] WB_WORD     = 4'b1111;
   localparam logic [WB_WIDTH-1:0] WB_LOW_HALF = 4'b0011;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR     = 3'd1,
      SIZE    = 3'd2,
      PAYLOAD = 3'd3,
      FLUSH   = 3'd4,
      DONE    = 3'd5
   } state_t;

endpackage

// File: rtl/ni_recv_dma_if.sv
// Tile dual-port RAM port-B interface; the DMA drives it through the master modport.
interface interface_memory;

   logic                                 enable_in;
   logic [ni_pkg::WB_WIDTH-1:0]          wb_in;
   logic [ni_pkg::ADDR_WIDTH-1:0]        addr_in;
   logic [ni_pkg::WORD_WIDTH-1:0]        data_in;
   logic [ni_pkg::WORD_WIDTH-1:0]        data_out;

   modport master (output enable_in, wb_in, addr_in, data_in, input data_out);
   modport slave  (input enable_in, wb_in, addr_in, data_in, output data_out);

endinterface

// File: rtl/ni_recv_dma_packer.sv
// Packs consecutive payload flits into 32-bit words; the first flit of a pair is held in low_half.
module flit_packer
   import ni_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  flit_en,
   input  logic [FLIT_WIDTH-1:0] flit_data,
   output logic                  word_valid_c,
   output logic [WORD_WIDTH-1:0] word_data_c,
   output logic                  partial,
   output logic [FLIT_WIDTH-1:0] low_half
);

   // partial toggles per accepted flit; set means low_half holds an unpaired flit
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         partial  <= 1'b0;
         low_half <= '0;
      end else if (clear) begin
         partial  <= 1'b0;
      end else if (flit_en) begin
         partial <= ~partial;
         if (!partial) begin
            low_half <= flit_data;
         end
      end
   end

   assign word_valid_c = flit_en & partial;
   assign word_data_c  = {flit_data, low_half};

endmodule

// File: rtl/ni_recv_dma.sv
// Receive DMA: strips header/size flits, packs payload flit pairs into words and writes them to RAM port B.
// Optional RECV_DMA_BOUND_CHECK_EN drops words beyond cfg_max_words and reports them on overflow.
module ni_recv_dma
   import ni_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cfg_start,
   input  logic [ADDR_WIDTH-1:0] cfg_base,
   input  logic [LEN_WIDTH-1:0]  cfg_max_words,
   input  logic                  flit_valid,
   input  logic [FLIT_WIDTH-1:0] flit_data,
   output logic                  flit_ready,
   interface_memory.master       mem_if,
   output logic                  busy,
   output logic                  done,
   output logic [LEN_WIDTH-1:0]  rx_words,
   output logic [FLIT_WIDTH-1:0] rx_src
`ifdef RECV_DMA_BOUND_CHECK_EN
   ,
   output logic                  overflow
`endif
);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic [LEN_WIDTH-1:0]  word_idx_q, word_idx_d;
   logic [LEN_WIDTH-1:0]  rx_words_d;
   logic [FLIT_WIDTH-1:0] rx_src_d;
   logic                  flit_ready_d, busy_d, done_d;
   logic                  mem_en_q, mem_en_d;
   logic [WB_WIDTH-1:0]   mem_wb_q, mem_wb_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_WIDTH-1:0] mem_data_q, mem_data_d;

   logic                  xfer_c, pack_en_c, clear_c;
   logic                  issue_c, in_bound_c;
   logic [WB_WIDTH-1:0]   issue_wb_c;
   logic [WORD_WIDTH-1:0] issue_data_c;
   logic                  word_valid_c;
   logic [WORD_WIDTH-1:0] word_data_c;
   logic                  partial;
   logic [FLIT_WIDTH-1:0] low_half;

`ifdef RECV_DMA_BOUND_CHECK_EN
   logic [LEN_WIDTH-1:0]  max_q, max_d;
   logic                  dropped_q, dropped_d;
   logic                  overflow_d;
`else
   logic                  unused_cfg_max;
   assign unused_cfg_max = ^cfg_max_words;
`endif

   assign xfer_c    = flit_valid & flit_ready;
   assign pack_en_c = xfer_c && (state_q == PAYLOAD);

   flit_packer u_packer (
      .clock        (clock),
      .reset        (reset),
      .clear        (clear_c),
      .flit_en      (pack_en_c),
      .flit_data    (flit_data),
      .word_valid_c (word_valid_c),
      .word_data_c  (word_data_c),
      .partial      (partial),
      .low_half     (low_half)
   );

   // Next-state and next-output logic; every output is registered from its _d value
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      remaining_d  = remaining_q;
      word_idx_d   = word_idx_q;
      rx_words_d   = rx_words;
      rx_src_d     = rx_src;
      mem_en_d     = 1'b0;
      mem_wb_d     = WB_NONE;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      clear_c      = 1'b0;
      issue_c      = 1'b0;
      issue_wb_c   = WB_WORD;
      issue_data_c = word_data_c;
`ifdef RECV_DMA_BOUND_CHECK_EN
      max_d        = max_q;
      dropped_d    = dropped_q;
      overflow_d   = overflow;
      in_bound_c   = (word_idx_q < max_q);
`else
      in_bound_c   = 1'b1;
`endif

      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               base_d      = cfg_base;
               remaining_d = '0;
               word_idx_d  = '0;
               rx_words_d  = '0;
               clear_c     = 1'b1;
`ifdef RECV_DMA_BOUND_CHECK_EN
               max_d       = cfg_max_words;
               dropped_d   = 1'b0;
               overflow_d  = 1'b0;
`endif
               state_d     = HDR;
            end
         end
         HDR: begin
            if (xfer_c) begin
               rx_src_d = flit_data;
               state_d  = SIZE;
            end
         end
         SIZE: begin
            if (xfer_c) begin
               remaining_d = flit_data;
               state_d     = (flit_data == '0) ? DONE : PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (xfer_c) begin
               remaining_d = remaining_q - LEN_WIDTH'(1);
               issue_c     = word_valid_c;
               if (remaining_q == LEN_WIDTH'(1)) begin
                  state_d = partial ? DONE : FLUSH;
               end
            end
         end
         FLUSH: begin
            issue_c      = 1'b1;
            issue_wb_c   = WB_LOW_HALF;
            issue_data_c = {FLIT_WIDTH'(0), low_half};
            state_d      = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Posted RAM write; address wraps modulo 2^ADDR_WIDTH
      if (issue_c && in_bound_c) begin
         mem_en_d   = 1'b1;
         mem_wb_d   = issue_wb_c;
         mem_addr_d = base_q + (ADDR_WIDTH'(word_idx_q) << 2);
         mem_data_d = issue_data_c;
         word_idx_d = word_idx_q + LEN_WIDTH'(1);
         rx_words_d = (rx_words == '1) ? rx_words : rx_words + LEN_WIDTH'(1);
      end
`ifdef RECV_DMA_BOUND_CHECK_EN
      if (issue_c && !in_bound_c) begin
         dropped_d = 1'b1;
      end
      if ((state_d == DONE) && (state_q != DONE)) begin
         overflow_d = dropped_d;
      end
`endif

      flit_ready_d = (state_d == HDR) || (state_d == SIZE) || (state_d == PAYLOAD);
      busy_d       = (state_d != IDLE);
      done_d       = (state_d == DONE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         base_q      <= '0;
         remaining_q <= '0;
         word_idx_q  <= '0;
         rx_words    <= '0;
         rx_src      <= '0;
         flit_ready  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_wb_q    <= WB_NONE;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
`ifdef RECV_DMA_BOUND_CHECK_EN
         max_q       <= '0;
         dropped_q   <= 1'b0;
         overflow    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         remaining_q <= remaining_d;
         word_idx_q  <= word_idx_d;
         rx_words    <= rx_words_d;
         rx_src      <= rx_src_d;
         flit_ready  <= flit_ready_d;
         busy        <= busy_d;
         done        <= done_d;
         mem_en_q    <= mem_en_d;
         mem_wb_q    <= mem_wb_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
`ifdef RECV_DMA_BOUND_CHECK_EN
         max_q       <= max_d;
         dropped_q   <= dropped_d;
         overflow    <= overflow_d;
`endif
      end
   end

   assign mem_if.enable_in = mem_en_q;
   assign mem_if.wb_in     = mem_wb_q;
   assign mem_if.addr_in   = mem_addr_q;
   assign mem_if.data_in   = mem_data_q;

endmodule

// File: tb/tb_ni_recv_dma.sv
// Self-checking bench for ni_recv_dma: packet vector table plus directed reset/stall/done-edge sequences.
module tb_ni_recv_dma;
   import ni_pkg::*;

   typedef struct {
      logic [31:0]       base;
      logic [15:0]       maxw;
      logic [15:0]       src;
      logic [15:0]       size;
      logic [3:0][15:0]  pl;
      int                nw;
      logic [1:0][31:0]  ea;
      logic [1:0][31:0]  ed;
      logic [1:0][3:0]   ew;
      logic [15:0]       erw;
      logic              eovf;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cfg_start = 1'b0;
   logic [31:0] cfg_base = '0;
   logic [15:0] cfg_max_words = '0;
   logic        flit_valid = 1'b0;
   logic [15:0] flit_data = '0;
   logic        flit_ready, busy, done;
   logic [15:0] rx_words, rx_src;
`ifdef RECV_DMA_BOUND_CHECK_EN
   logic        overflow;
`endif

   int checks = 0;
   int fails  = 0;
   int done_cnt = 0;
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   logic [3:0]  ww_q[$];
   vec_t        vecs[5];

   always #5 clock = ~clock;

   interface_memory mem_if ();
   assign mem_if.data_out = '0;

   ni_recv_dma dut (
      .clock         (clock),
      .reset         (reset),
      .cfg_start     (cfg_start),
      .cfg_base      (cfg_base),
      .cfg_max_words (cfg_max_words),
      .flit_valid    (flit_valid),
      .flit_data     (flit_data),
      .flit_ready    (flit_ready),
      .mem_if        (mem_if),
      .busy          (busy),
      .done          (done),
      .rx_words      (rx_words),
      .rx_src        (rx_src)
`ifdef RECV_DMA_BOUND_CHECK_EN
      ,
      .overflow      (overflow)
`endif
   );

   // Log RAM writes and done pulses away from the active edge
   always @(negedge clock) begin
      if (reset && mem_if.enable_in) begin
         wa_q.push_back(mem_if.addr_in);
         wd_q.push_back(mem_if.data_in);
         ww_q.push_back(mem_if.wb_in);
      end
      if (reset && done) done_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic send_flit(input logic [15:0] d, input bit gaps);
      int k;
      if (gaps) begin
         flit_valid = 1'b0;
         flit_data  = 16'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      flit_valid = 1'b1;
      flit_data  = d;
      for (k = 0; k < 50 && !flit_ready; k++) @(negedge clock);
      if (!flit_ready) begin
         checks++;
         fails++;
         $display("FAIL flit_accept_timeout actual=0 expected=1 flit=%h", d);
      end else begin
         @(posedge clock);
         @(negedge clock);
      end
      flit_valid = 1'b0;
   endtask

   task automatic run_pkt(input vec_t v, input bit gaps);
      int d0;
      int q0;
      d0 = done_cnt;
      q0 = wa_q.size();
      cfg_base      = v.base;
      cfg_max_words = v.maxw;
      cfg_start     = 1'b1;
      @(negedge clock);
      cfg_start     = 1'b0;
      chk("busy_armed", 32'(busy), 32'd1);
      send_flit(v.src, gaps);
      send_flit(v.size, gaps);
      for (int i = 0; i < int'(v.size); i++) begin
         send_flit(v.pl[i], gaps);
         if (gaps && i == 0) begin
            cfg_base  = 32'hDEAD_0000;
            cfg_start = 1'b1;
            @(negedge clock);
            cfg_start = 1'b0;
         end
      end
      for (int k = 0; k < 20 && done_cnt == d0; k++) @(negedge clock);
      repeat (3) @(negedge clock);
      chk("done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("write_count", 32'(wa_q.size() - q0), 32'(v.nw));
      for (int i = 0; i < v.nw; i++) begin
         chk("wr_addr", (q0 + i < wa_q.size()) ? wa_q[q0+i] : 32'hxxxx_xxxx, v.ea[i]);
         chk("wr_data", (q0 + i < wd_q.size()) ? wd_q[q0+i] : 32'hxxxx_xxxx, v.ed[i]);
         chk("wr_wb",   (q0 + i < ww_q.size()) ? 32'(ww_q[q0+i]) : 32'hxxxx_xxxx, 32'(v.ew[i]));
      end
      chk("rx_words", 32'(rx_words), 32'(v.erw));
      chk("rx_src",   32'(rx_src), 32'(v.src));
      chk("busy_idle", 32'(busy), 32'd0);
`ifdef RECV_DMA_BOUND_CHECK_EN
      chk("overflow", 32'(overflow), 32'(v.eovf));
`endif
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_flit_ready"}, 32'(flit_ready), 32'd0);
      chk({tag, "_enable"},     32'(mem_if.enable_in), 32'd0);
      chk({tag, "_wb"},         32'(mem_if.wb_in), 32'd0);
      chk({tag, "_addr"},       mem_if.addr_in, 32'd0);
      chk({tag, "_data"},       mem_if.data_in, 32'd0);
      chk({tag, "_busy"},       32'(busy), 32'd0);
      chk({tag, "_done"},       32'(done), 32'd0);
      chk({tag, "_rx_words"},   32'(rx_words), 32'd0);
      chk({tag, "_rx_src"},     32'(rx_src), 32'd0);
`ifdef RECV_DMA_BOUND_CHECK_EN
      chk({tag, "_overflow"},   32'(overflow), 32'd0);
`endif
   endtask

   initial begin
      int q0;
      vec_t vb;
      vecs[0] = '{32'h0000_0100, 16'd8, 16'h0011, 16'd4, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA},
                  2, {32'h0000_0104, 32'h0000_0100}, {32'hDDDD_CCCC, 32'hBBBB_AAAA}, {4'hF, 4'hF}, 16'd2, 1'b0};
      vecs[1] = '{32'h0000_0200, 16'd8, 16'h0022, 16'd3, {16'h0000, 16'h3333, 16'h2222, 16'h1111},
                  2, {32'h0000_0204, 32'h0000_0200}, {32'h0000_3333, 32'h2222_1111}, {4'h3, 4'hF}, 16'd2, 1'b0};
      vecs[2] = '{32'h0000_0300, 16'd8, 16'h0033, 16'd0, {16'h0, 16'h0, 16'h0, 16'h0},
                  0, {32'h0, 32'h0}, {32'h0, 32'h0}, {4'h0, 4'h0}, 16'd0, 1'b0};
      vecs[3] = '{32'hFFFF_FFFC, 16'd8, 16'h0044, 16'd4, {16'h0004, 16'h0003, 16'h0002, 16'h0001},
                  2, {32'h0000_0000, 32'hFFFF_FFFC}, {32'h0004_0003, 32'h0002_0001}, {4'hF, 4'hF}, 16'd2, 1'b0};
      vecs[4] = '{32'h0000_0500, 16'd8, 16'h0055, 16'd1, {16'h0, 16'h0, 16'h0, 16'h5555},
                  1, {32'h0, 32'h0000_0500}, {32'h0, 32'h0000_5555}, {4'h0, 4'h3}, 16'd1, 1'b0};

      repeat (2) @(negedge clock);
      chk_reset_values("por");
      reset = 1'b1;
      @(negedge clock);

      // flit_valid while idle must not be consumed or start anything
      flit_valid = 1'b1;
      flit_data  = 16'hBEEF;
      repeat (3) @(negedge clock);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ready", 32'(flit_ready), 32'd0);
      chk("idle_writes", 32'(wa_q.size()), 32'd0);
      flit_valid = 1'b0;

      for (int i = 0; i < 5; i++) run_pkt(vecs[i], 1'b0);

      // gapped stream with an ignored mid-packet cfg_start
      run_pkt(vecs[0], 1'b1);
      run_pkt(vecs[1], 1'b1);
      run_pkt(vecs[3], 1'b1);

      // size 0: done the cycle after the size flit; cfg_start in DONE is ignored
      q0 = wa_q.size();
      cfg_base  = 32'h0000_0600;
      cfg_start = 1'b1;
      @(negedge clock);
      cfg_start = 1'b0;
      send_flit(16'h0066, 1'b0);
      send_flit(16'h0000, 1'b0);
      chk("sz0_done", 32'(done), 32'd1);
      chk("sz0_enable", 32'(mem_if.enable_in), 32'd0);
      chk("sz0_rx_words", 32'(rx_words), 32'd0);
      chk("sz0_rx_src", 32'(rx_src), 32'h0066);
      cfg_start = 1'b1;
      @(negedge clock);
      cfg_start = 1'b0;
      chk("done_cfg_busy", 32'(busy), 32'd0);
      chk("done_cfg_done", 32'(done), 32'd0);
      @(negedge clock);
      chk("done_cfg_busy2", 32'(busy), 32'd0);
      chk("sz0_writes", 32'(wa_q.size() - q0), 32'd0);

      // reset asserted in PAYLOAD, in the cycle a write is posted
      cfg_base  = 32'h0000_0800;
      cfg_max_words = 16'd8;
      cfg_start = 1'b1;
      @(negedge clock);
      cfg_start = 1'b0;
      send_flit(16'h0088, 1'b0);
      send_flit(16'h0004, 1'b0);
      send_flit(16'hAAAA, 1'b0);
      send_flit(16'hBBBB, 1'b0);
      chk("pre_rst_enable", 32'(mem_if.enable_in), 32'd1);
      chk("pre_rst_data", mem_if.data_in, 32'hBBBB_AAAA);
      reset = 1'b0;
      #1;
      chk_reset_values("mid_rst");
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      run_pkt(vecs[0], 1'b0);

`ifdef RECV_DMA_BOUND_CHECK_EN
      vb = '{32'h0000_0700, 16'd1, 16'h0077, 16'd4, {16'h0004, 16'h0003, 16'h0002, 16'h0001},
             1, {32'h0, 32'h0000_0700}, {32'h0, 32'h0002_0001}, {4'h0, 4'hF}, 16'd1, 1'b1};
      run_pkt(vb, 1'b0);
      cfg_base  = 32'h0000_0900;
      cfg_max_words = 16'd8;
      cfg_start = 1'b1;
      @(negedge clock);
      cfg_start = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);
      send_flit(16'h0099, 1'b0);
      send_flit(16'h0000, 1'b0);
      repeat (2) @(negedge clock);
`else
      vb = vecs[2];
      run_pkt(vb, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
